// File: rtl/snn_seq_pkg.sv
// Shared constants for the image sequencer: FSM state codes, step index width
// and the width helper for the shared down-counter.
package snn_seq_pkg;

    localparam int unsigned STEP_W = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_FIRE = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_REST = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    // Bits needed to hold the larger of two counts, never less than one.
    function automatic int unsigned ctr_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        if (m < 32'd1) begin
            m = 32'd1;
        end else begin
            m = m;
        end
        return $clog2(m + 32'd1);
    endfunction

endpackage

// File: rtl/seq_down_ctr.sv
// Loadable saturating down-counter with a zero flag; shared by the rest
// period and the WAIT timeout of the image sequencer.
module seq_down_ctr #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over decrement, decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/snn_img_sequencer.sv
// Sequences one image presentation: LOAD pulse, T_STEPS fire/wait steps, rest, done.
// Optional WAIT timeout with sticky err_timeout when SEQ_TIMEOUT_EN is defined.
module snn_img_sequencer
    import snn_seq_pkg::*;
#(
    parameter int unsigned T_STEPS = 64,
    parameter int unsigned REST    = 16,
    parameter int unsigned TMO     = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              img_req_valid,
    output logic              img_req_ready,
    input  logic              abort,
    input  logic              valid_ip_nub,
    input  logic              core_step_done,
    output logic              start_core_img,
    output logic              start_ip_nub,
    output logic [STEP_W-1:0] step_idx,
    output logic              busy,
`ifdef SEQ_TIMEOUT_EN
    output logic              err_timeout,
`endif
    output logic              img_done
);

    localparam int unsigned CTR_W = ctr_width(REST, TMO);
    localparam logic [CTR_W-1:0] REST_LOAD = CTR_W'((REST > 32'd0) ? (REST - 32'd1) : 32'd0);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(T_STEPS - 32'd1);
`ifdef SEQ_TIMEOUT_EN
    localparam logic [CTR_W-1:0] TMO_LOAD = CTR_W'((TMO > 32'd0) ? (TMO - 32'd1) : 32'd0);
`endif

    logic [2:0]        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              ip_seen_q, ip_seen_d;
    logic              core_seen_q, core_seen_d;
    logic              ctr_load;
    logic [CTR_W-1:0]  ctr_load_val;
    logic              ctr_dec;
    logic              ctr_zero;
    logic              step_ok;
`ifdef SEQ_TIMEOUT_EN
    logic              err_q, err_d;
`endif

    // Registered flags plus this cycle's inputs, so a step can close on the done cycle itself.
    assign step_ok = (ip_seen_q | valid_ip_nub) & (core_seen_q | core_step_done);

    // Next-state, step counter, sticky flags and counter control.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        ip_seen_d    = ip_seen_q;
        core_seen_d  = core_seen_q;
        ctr_load     = 1'b0;
        ctr_load_val = REST_LOAD;
        ctr_dec      = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        err_d        = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (img_req_valid) begin
                    state_d = ST_LOAD;
                    step_d  = '0;
`ifdef SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: state_d = ST_FIRE;
            ST_FIRE: begin
                // Done indications seen here belong to the previous step.
                ip_seen_d   = 1'b0;
                core_seen_d = 1'b0;
                state_d     = ST_WAIT;
`ifdef SEQ_TIMEOUT_EN
                ctr_load     = 1'b1;
                ctr_load_val = TMO_LOAD;
`endif
            end
            ST_WAIT: begin
                ip_seen_d   = ip_seen_q | valid_ip_nub;
                core_seen_d = core_seen_q | core_step_done;
`ifdef SEQ_TIMEOUT_EN
                ctr_dec     = 1'b1;
`endif
                if (step_ok) begin
                    if (step_q == STEP_LAST) begin
                        if (REST == 32'd0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d      = ST_REST;
                            ctr_load     = 1'b1;
                            ctr_load_val = REST_LOAD;
                        end
                    end else begin
                        step_d  = step_q + 16'd1;
                        state_d = ST_FIRE;
                    end
                end else begin
`ifdef SEQ_TIMEOUT_EN
                    if (ctr_zero) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
`else
                    state_d = ST_WAIT;
`endif
                end
            end
            ST_REST: begin
                if (ctr_zero) begin
                    state_d = ST_DONE;
                end else begin
                    ctr_dec = 1'b1;
                    state_d = ST_REST;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort outranks timeout and normal progress; step index is frozen.
        if (abort && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            step_d   = step_q;
            ctr_load = 1'b0;
`ifdef SEQ_TIMEOUT_EN
            err_d    = err_q;
`endif
        end else begin
            state_d = state_d;
        end
    end

    // FSM, step index and sticky done flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            ip_seen_q   <= 1'b0;
            core_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            ip_seen_q   <= ip_seen_d;
            core_seen_q <= core_seen_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Sticky timeout flag, cleared only by the next accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`endif

    seq_down_ctr #(
        .W (CTR_W)
    ) u_ctr (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (ctr_load),
        .load_val_i (ctr_load_val),
        .dec_i      (ctr_dec),
        .zero_o     (ctr_zero)
    );

    assign img_req_ready  = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign start_core_img = (state_q == ST_LOAD);
    assign start_ip_nub   = (state_q == ST_FIRE);
    assign img_done       = (state_q == ST_DONE);
    assign step_idx       = step_q;

endmodule

// File: tb/tb_snn_img_sequencer.sv
// Randomized bench for snn_img_sequencer: a timeline model predicts every output per cycle.
module tb_snn_img_sequencer;

    localparam int T      = 4;
    localparam int P_REST = 2;
    localparam int TO     = 10;
    localparam int NEVER  = 1000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        img_req_valid, abort, valid_ip_nub, core_step_done;
    logic        img_req_ready, start_core_img, start_ip_nub, busy, img_done;
    logic [15:0] step_idx;
`ifdef SEQ_TIMEOUT_EN
    logic        err_timeout;
`endif

    snn_img_sequencer #(.T_STEPS(T), .REST(P_REST), .TMO(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .img_req_valid  (img_req_valid),
        .img_req_ready  (img_req_ready),
        .abort          (abort),
        .valid_ip_nub   (valid_ip_nub),
        .core_step_done (core_step_done),
        .start_core_img (start_core_img),
        .start_ip_nub   (start_ip_nub),
        .step_idx       (step_idx),
        .busy           (busy),
`ifdef SEQ_TIMEOUT_EN
        .err_timeout    (err_timeout),
`endif
        .img_done       (img_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int d_ip   [T];
    int d_core [T];
    bit fnoise [T];
    int abort_step, abort_off, tmo_step, rst_step, rst_off;
    int prev_step;
    bit prev_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, 32'(img_req_ready), 32'd1);
        check_eq({tag, "_busy"},  32'(busy), 32'd0);
        check_eq({tag, "_core"},  32'(start_core_img), 32'd0);
        check_eq({tag, "_ip"},    32'(start_ip_nub), 32'd0);
        check_eq({tag, "_done"},  32'(img_done), 32'd0);
        check_eq({tag, "_step"},  32'(step_idx), 32'd0);
`ifdef SEQ_TIMEOUT_EN
        check_eq({tag, "_err"},   32'(err_timeout), 32'd0);
`endif
    endtask

    task automatic clear_cfg();
        abort_step = -1; abort_off = 0; tmo_step = -1; rst_step = -1; rst_off = 0;
    endtask

    task automatic set_all(input int di, input int dc, input bit nz);
        for (int k = 0; k < T; k++) begin
            d_ip[k] = di; d_core[k] = dc; fnoise[k] = nz;
        end
    endtask

    // One presentation: build the expected timeline, then drive and compare cycle by cycle.
    task automatic present();
        int f [T];
        int e [T];
        int nk, end_cyc, done_cyc, abort_cyc, rst_cyc, last_st;
        bit timed_out;
        nk = T; done_cyc = -1; end_cyc = 0; timed_out = 1'b0; last_st = 0;
        f[0] = 2;
        for (int k = 0; k < T; k++) begin
            if (k > 0) f[k] = e[k-1] + 1;
            if (k == tmo_step) begin
                e[k] = f[k] + TO; end_cyc = f[k] + TO + 1; nk = k + 1; timed_out = 1'b1;
                break;
            end
            e[k] = f[k] + ((d_ip[k] > d_core[k]) ? d_ip[k] : d_core[k]);
            if (k == T - 1) begin
                done_cyc = e[k] + P_REST + 1; end_cyc = done_cyc + 1;
            end
        end
        abort_cyc = (abort_step >= 0 && abort_step < nk) ? f[abort_step] + abort_off : -1;
        if (abort_cyc >= 1 && abort_cyc < end_cyc) begin
            end_cyc = abort_cyc + 1;
            timed_out = 1'b0;
            if (done_cyc >= end_cyc) done_cyc = -1;
        end
        rst_cyc = (rst_step >= 0 && rst_step < nk) ? f[rst_step] + rst_off : -1;
        for (int c = 0; c <= end_cyc + 1; c++) begin
            int kk, st, d, lim;
            bit bz, ipx, errx;
            @(negedge clk);
            bz  = (c >= 1) && (c < end_cyc);
            lim = (c < end_cyc) ? c : end_cyc - 1;
            st  = (c == 0) ? prev_step : 0;
            ipx = 1'b0;
            kk  = -1;
            for (int k = 0; k < nk; k++) begin
                if (c >= 1 && f[k] <= lim) st = k;
                if (bz && f[k] == c) ipx = 1'b1;
                if (f[k] <= c && c <= e[k]) kk = k;
            end
            errx = (c == 0) ? prev_err : (timed_out && c >= end_cyc);
            last_st = st;
            check_eq("ready",    32'(img_req_ready),  32'(!bz));
            check_eq("busy",     32'(busy),           32'(bz));
            check_eq("core_img", 32'(start_core_img), 32'(bz && c == 1));
            check_eq("ip_nub",   32'(start_ip_nub),   32'(ipx));
            check_eq("img_done", 32'(img_done),       32'(c == done_cyc));
            check_eq("step_idx", 32'(step_idx),       32'(st));
`ifdef SEQ_TIMEOUT_EN
            check_eq("err_tmo",  32'(err_timeout),    32'(errx));
`endif
            if (c == rst_cyc) begin
                img_req_valid = 1'b0; abort = 1'b0; valid_ip_nub = 1'b0; core_step_done = 1'b0;
                #2 rst = 1'b0;
                #1 check_reset_vals("async_rst");
                @(negedge clk);
                check_reset_vals("held_rst");
                rst = 1'b1;
                prev_step = 0; prev_err = 1'b0;
                return;
            end
            img_req_valid = (c == 0);
            abort = (c == abort_cyc) || (c == 0 && $urandom_range(0, 1) == 1);
            if (kk >= 0) begin
                d = c - f[kk];
                valid_ip_nub   = (d == 0) ? fnoise[kk] : (d == d_ip[kk]) ? 1'b1 :
                                 (d > d_ip[kk]) ? 1'($urandom_range(0, 1)) : 1'b0;
                core_step_done = (d == 0) ? fnoise[kk] : (d == d_core[kk]) ? 1'b1 :
                                 (d > d_core[kk]) ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                valid_ip_nub   = 1'($urandom_range(0, 1));
                core_step_done = 1'($urandom_range(0, 1));
            end
        end
        img_req_valid = 1'b0; abort = 1'b0;
        prev_step = last_st;
        prev_err  = timed_out;
    endtask

    initial begin
        rst = 1'b1;
        img_req_valid = 1'b0; abort = 1'b0; valid_ip_nub = 1'b0; core_step_done = 1'b0;
        prev_step = 0; prev_err = 1'b0;
        clear_cfg();
        #2 rst = 1'b0;
        #1 check_reset_vals("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Basic run: both dones 3 cycles after each start_ip_nub.
        set_all(3, 3, 1'b0);
        present();

        // Skewed done signals: ip first, core first, together, minimum step.
        d_ip[0] = 2; d_core[0] = 7;
        d_ip[1] = 7; d_core[1] = 2;
        d_ip[2] = 3; d_core[2] = 3;
        d_ip[3] = 1; d_core[3] = 1;
        present();

        // Stale done held through FIRE must not advance the step.
        set_all(4, 1, 1'b1);
        present();

        // Abort in WAIT of step 1, then a fresh request restarts at step 0.
        set_all(5, 5, 1'b0);
        abort_step = 1; abort_off = 2;
        present();
        clear_cfg();
        set_all(2, 3, 1'b0);
        present();

`ifdef SEQ_TIMEOUT_EN
        // Timeout: core never answers in step 1; flag clears on the next accept.
        set_all(2, 2, 1'b0);
        d_core[1] = NEVER;
        tmo_step = 1;
        present();
        clear_cfg();
        set_all(2, 2, 1'b0);
        present();
`endif

        // Reset mid-WAIT, then a basic run.
        set_all(5, 5, 1'b0);
        rst_step = 0; rst_off = 2;
        present();
        clear_cfg();
        set_all(3, 3, 1'b0);
        present();

        // Randomized presentations with occasional aborts.
        for (int n = 0; n < 24; n++) begin
            clear_cfg();
            for (int k = 0; k < T; k++) begin
                d_ip[k]   = int'($urandom_range(1, 8));
                d_core[k] = int'($urandom_range(1, 8));
                fnoise[k] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 3) == 0) begin
                abort_step = int'($urandom_range(0, T - 1));
                abort_off  = int'($urandom_range(0, 4));
            end
            present();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
